// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between spi_reg_ctrl (master), the SPI slave byte engine and the register file.
// master: the controller; slave: the SPI byte engine / register file side.
interface spi_reg_ctrl_if;
  logic       transaction_begin;
  logic       rx_byte_available;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport master (
    input  transaction_begin,
    input  rx_byte_available,
    input  rx_byte,
    input  reg_rdata,
    output tx_byte,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    output busy
  );

  modport slave (
    output transaction_begin,
    output rx_byte_available,
    output rx_byte,
    output reg_rdata,
    input  tx_byte,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    input  busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte stream to register-bus bridge: command byte (dir + 7-bit address), then data bytes.
// Define SPI_REG_CTRL_AUTOINC_EN to advance reg_addr after every data byte; otherwise it holds.
module spi_reg_ctrl #(
  parameter logic [7:0] TX_IDLE_BYTE = 8'h00
) (
  input logic            clk,
  input logic            reset,
  spi_reg_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdFetch,
    StRdLoad,
    StRdData
  } state_e;

  state_e     state_q, state_d;
  logic       rx_avail_q;
  logic       byte_evt;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;
  logic [6:0] cmd_addr;
  logic       cmd_read;
  logic [6:0] addr_next;

  assign byte_evt = bus.rx_byte_available & ~rx_avail_q;

  // rx_byte[0] is the first bit on the wire (command MSB), so the address arrives MSB at [1].
  assign cmd_read = bus.rx_byte[0];
  assign cmd_addr = {bus.rx_byte[1], bus.rx_byte[2], bus.rx_byte[3], bus.rx_byte[4],
                     bus.rx_byte[5], bus.rx_byte[6], bus.rx_byte[7]};

`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign addr_next = addr_q + 7'd1;
`else
  assign addr_next = addr_q;
`endif

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy_q;

    if (bus.transaction_begin) begin
      // Restart wins over any byte completing in the same clk; pending strobes are dropped.
      state_d   = StCmd;
      tx_byte_d = TX_IDLE_BYTE;
      busy_d    = 1'b1;
    end else begin
      // The address advances in the clk after the write strobe has been seen with it.
      if (we_q) begin
        addr_d = addr_next;
      end
      unique case (state_q)
        StIdle: begin
        end
        StCmd: begin
          if (byte_evt) begin
            addr_d = cmd_addr;
            if (cmd_read) begin
              state_d = StRdFetch;
              re_d    = 1'b1;
            end else begin
              state_d = StWrData;
            end
          end
        end
        StWrData: begin
          if (byte_evt) begin
            wdata_d = bus.rx_byte;
            we_d    = 1'b1;
          end
        end
        StRdFetch: begin
          state_d = StRdLoad;
        end
        StRdLoad: begin
          tx_byte_d = bus.reg_rdata;
          addr_d    = addr_next;
          state_d   = StRdData;
        end
        StRdData: begin
          if (byte_evt) begin
            state_d = StRdFetch;
            re_d    = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rx_avail_q <= 1'b0;
      tx_byte_q  <= TX_IDLE_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_avail_q <= bus.rx_byte_available;
      tx_byte_q  <= tx_byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

  // re_q is set only on entry to StRdFetch, so it is high exactly while fetching.
  a_re_in_fetch: assert property (@(posedge clk) disable iff (reset)
    re_q |-> state_q == StRdFetch);
  a_no_we_re: assert property (@(posedge clk) disable iff (reset) !(we_q && re_q));

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed vector table, hand-written abort/reset sequences and
// randomized transactions checked against a transaction-level model.
module tb_spi_reg_ctrl;

  localparam logic [7:0] IdleByte = 8'hA5;
`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  // cmd is the byte value as sent on the wire (MSB = direction, first on the wire).
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] a0;
    logic [6:0] a1;
    logic [7:0] t0;
    logic [7:0] t1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  bit   both_seen = 1'b0;

  wr_t        wq[$];
  wr_t        exp_wq[$];
  logic [6:0] rq[$];
  logic [6:0] exp_rq[$];
  vec_t       vecs[5];

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(
    .TX_IDLE_BYTE(IdleByte)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_value(input logic [6:0] a);
    return 8'h10 + {1'b0, a};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [6:0] model_addr(input logic [6:0] base, input int k);
    int v;
    v = int'(base) + (AutoInc ? k : 0);
    return 7'(v % 128);
  endfunction

  // Register file: read data valid for the one clk after reg_re, junk otherwise.
  always @(posedge clk) bus.reg_rdata <= bus.reg_re ? rd_value(bus.reg_addr) : 8'hEE;

  always @(negedge clk) begin
    if (bus.reg_we) wq.push_back('{a: bus.reg_addr, d: bus.reg_wdata});
    if (bus.reg_re) rq.push_back(bus.reg_addr);
    if (bus.reg_we && bus.reg_re) both_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pulse_begin();
    @(negedge clk);
    bus.transaction_begin = 1'b1;
    @(negedge clk);
    bus.transaction_begin = 1'b0;
  endtask

  // tx_byte is checked three clks after the byte is presented.
  task automatic send_byte(input logic [7:0] b, input bit chk, input logic [7:0] exp_tx,
                           input string name);
    @(negedge clk);
    bus.rx_byte           = b;
    bus.rx_byte_available = 1'b1;
    repeat (3) @(negedge clk);
    if (chk) check(name, 32'(bus.tx_byte), 32'(exp_tx));
    @(negedge clk);
    bus.rx_byte_available = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_and_clear(input string name);
    check($sformatf("%s write count", name), 32'(wq.size()), 32'(exp_wq.size()));
    for (int i = 0; i < exp_wq.size(); i++)
      if (i < wq.size())
        check($sformatf("%s write%0d addr/data", name, i), {17'd0, wq[i].a, wq[i].d},
              {17'd0, exp_wq[i].a, exp_wq[i].d});
    check($sformatf("%s read count", name), 32'(rq.size()), 32'(exp_rq.size()));
    for (int i = 0; i < exp_rq.size(); i++)
      if (i < rq.size())
        check($sformatf("%s read%0d addr", name, i), 32'(rq[i]), 32'(exp_rq[i]));
    wq.delete();
    rq.delete();
    exp_wq.delete();
    exp_rq.delete();
  endtask

  task automatic run_random_txn(input int idx);
    logic [6:0] a;
    logic [7:0] d;
    bit         rd;
    int         n;
    string      nm;
    nm = $sformatf("rand%0d", idx);
    a  = ($urandom_range(0, 3) == 0) ? 7'(7'h7C + $urandom_range(0, 3)) : 7'($urandom_range(0, 127));
    rd = 1'($urandom_range(0, 1));
    n  = $urandom_range(1, 4);
    pulse_begin();
    send_byte(rev8({rd, a}), rd, rd_value(model_addr(a, 0)), {nm, " tx0"});
    if (rd) begin
      exp_rq.push_back(model_addr(a, 0));
      for (int k = 1; k <= n; k++) begin
        send_byte(8'($urandom), 1'b1, rd_value(model_addr(a, k)), $sformatf("%s tx%0d", nm, k));
        exp_rq.push_back(model_addr(a, k));
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send_byte(d, 1'b0, 8'h00, nm);
        exp_wq.push_back('{a: model_addr(a, k), d: d});
      end
    end
    check({nm, " busy"}, 32'(bus.busy), 32'd1);
    compare_and_clear(nm);
  endtask

  initial begin
    vecs[0] = '{cmd: 8'h05, d0: 8'h3C, d1: 8'hC3, a0: 7'd5, a1: AutoInc ? 7'd6 : 7'd5,
                t0: 8'h00, t1: 8'h00};
    vecs[1] = '{cmd: 8'h7F, d0: 8'h5A, d1: 8'hA5, a0: 7'd127, a1: AutoInc ? 7'd0 : 7'd127,
                t0: 8'h00, t1: 8'h00};
    vecs[2] = '{cmd: 8'h8A, d0: 8'h99, d1: 8'h00, a0: 7'd10, a1: AutoInc ? 7'd11 : 7'd10,
                t0: 8'h1A, t1: AutoInc ? 8'h1B : 8'h1A};
    vecs[3] = '{cmd: 8'hFF, d0: 8'h66, d1: 8'h00, a0: 7'd127, a1: AutoInc ? 7'd0 : 7'd127,
                t0: 8'h8F, t1: AutoInc ? 8'h10 : 8'h8F};
    vecs[4] = '{cmd: 8'h40, d0: 8'h00, d1: 8'hFF, a0: 7'd64, a1: AutoInc ? 7'd65 : 7'd64,
                t0: 8'h00, t1: 8'h00};

    bus.transaction_begin = 1'b0;
    bus.rx_byte_available = 1'b0;
    bus.rx_byte           = 8'h00;
    reset                 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset tx_byte", 32'(bus.tx_byte), 32'(IdleByte));
    check("reset reg_addr", 32'(bus.reg_addr), 32'd0);
    check("reset reg_wdata", 32'(bus.reg_wdata), 32'd0);
    check("reset reg_we", 32'(bus.reg_we), 32'd0);
    check("reset reg_re", 32'(bus.reg_re), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    wq.delete();
    rq.delete();

    // Bytes before any transaction_begin are ignored.
    send_byte(rev8(8'h05), 1'b0, 8'h00, "idle");
    send_byte(8'h12, 1'b0, 8'h00, "idle");
    check("idle busy", 32'(bus.busy), 32'd0);
    compare_and_clear("idle");

    for (int i = 0; i < 5; i++) begin
      pulse_begin();
      if (vecs[i].cmd[7]) begin
        send_byte(rev8(vecs[i].cmd), 1'b1, vecs[i].t0, $sformatf("vec%0d tx0", i));
        exp_rq.push_back(vecs[i].a0);
        send_byte(vecs[i].d0, 1'b1, vecs[i].t1, $sformatf("vec%0d tx1", i));
        exp_rq.push_back(vecs[i].a1);
      end else begin
        send_byte(rev8(vecs[i].cmd), 1'b0, 8'h00, "");
        send_byte(vecs[i].d0, 1'b0, 8'h00, "");
        send_byte(vecs[i].d1, 1'b0, 8'h00, "");
        exp_wq.push_back('{a: vecs[i].a0, d: vecs[i].d0});
        exp_wq.push_back('{a: vecs[i].a1, d: vecs[i].d1});
      end
      compare_and_clear($sformatf("vec%0d", i));
    end

    // transaction_begin in the same clk as a byte_evt in the write phase.
    pulse_begin();
    send_byte(rev8(8'h20), 1'b0, 8'h00, "");
    send_byte(8'h11, 1'b0, 8'h00, "");
    exp_wq.push_back('{a: 7'h20, d: 8'h11});
    @(negedge clk);
    bus.rx_byte           = 8'h22;
    bus.rx_byte_available = 1'b1;
    bus.transaction_begin = 1'b1;
    @(negedge clk);
    bus.transaction_begin = 1'b0;
    check("abort wr busy", 32'(bus.busy), 32'd1);
    check("abort wr tx_byte", 32'(bus.tx_byte), 32'(IdleByte));
    repeat (3) @(negedge clk);
    bus.rx_byte_available = 1'b0;
    repeat (8) @(negedge clk);
    compare_and_clear("abort wr");
    send_byte(rev8(8'h03), 1'b0, 8'h00, "");
    send_byte(8'h77, 1'b0, 8'h00, "");
    exp_wq.push_back('{a: 7'h03, d: 8'h77});
    compare_and_clear("after abort wr");

    // Restart from the read data phase reloads the idle byte.
    pulse_begin();
    send_byte(rev8(8'h85), 1'b1, 8'h15, "abort rd tx0");
    exp_rq.push_back(7'd5);
    pulse_begin();
    check("abort rd tx_byte", 32'(bus.tx_byte), 32'(IdleByte));
    compare_and_clear("abort rd");

    // One-clk reset while the controller sits in RD_LOAD.
    pulse_begin();
    send_byte(rev8(8'h8A), 1'b1, 8'h1A, "rst rd tx0");
    exp_rq.push_back(7'd10);
    @(negedge clk);
    bus.rx_byte           = 8'h33;
    bus.rx_byte_available = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rq.push_back(model_addr(7'd10, 1));
    check("rst rd busy", 32'(bus.busy), 32'd0);
    check("rst rd reg_re", 32'(bus.reg_re), 32'd0);
    check("rst rd tx_byte", 32'(bus.tx_byte), 32'(IdleByte));
    repeat (2) @(negedge clk);
    bus.rx_byte_available = 1'b0;
    repeat (8) @(negedge clk);
    compare_and_clear("rst rd");
    send_byte(rev8(8'h05), 1'b0, 8'h00, "");
    send_byte(8'h44, 1'b0, 8'h00, "");
    check("post rst busy", 32'(bus.busy), 32'd0);
    check("post rst tx_byte", 32'(bus.tx_byte), 32'(IdleByte));
    compare_and_clear("post rst");

    for (int i = 0; i < 14; i++) run_random_txn(i);

    check("we and re never together", 32'(both_seen), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter TX_IDLE_BYTE, default 8'h00, the byte presented on tx_byte during the command byte and in the write phase.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port transaction_begin, input, 1, a one-clk pulse from the SPI slave when chip select falls.
REQ-005 SHALL have port rx_byte_available, input, 1, a level from the SPI slave; its 0->1 transition marks a completed received byte.
REQ-006 SHALL have port rx_byte, input, 8, the received byte; rx_byte[0] is the first-received bit (MSB).
REQ-007 SHALL have port tx_byte, output, 8, the byte for the SPI slave to shift out; tx_byte[0] is sent first.
REQ-008 SHALL have port reg_addr, output, 7, the register address.
REQ-009 SHALL have port reg_wdata, output, 8, the register write data.
REQ-010 SHALL have port reg_we, output, 1, a one-clk write strobe.
REQ-011 SHALL have port reg_re, output, 1, a one-clk read strobe.
REQ-012 SHALL have port reg_rdata, input, 8, the read data, valid exactly one clk after reg_re.
REQ-013 SHALL have port busy, output, 1, high from transaction_begin until the controller returns to IDLE.

Function
REQ-014 SHALL detect a new byte as rx_byte_available registered 0 -> current 1 (byte_evt), with 1-clk detection latency.
REQ-015 SHALL implement the states IDLE, CMD, WR_DATA, RD_FETCH, RD_LOAD and RD_DATA.
REQ-016 SHALL enter CMD from any state on transaction_begin, load tx_byte=TX_IDLE_BYTE and set busy=1; transaction_begin takes priority over a simultaneous byte_evt.
REQ-017 SHALL, on byte_evt in CMD, latch reg_addr=rx_byte bits [1..7] and direction=rx_byte[0] (1=read, 0=write), then go to RD_FETCH if reading, else WR_DATA.
REQ-018 SHALL, on each byte_evt in WR_DATA, drive reg_wdata=rx_byte and pulse reg_we for one clk in the next clk with the current reg_addr, then advance the address (REQ-024).
REQ-019 SHALL, in RD_FETCH, pulse reg_re for one clk and go to RD_LOAD.
REQ-020 SHALL, in RD_LOAD, capture reg_rdata into tx_byte, advance the address and go to RD_DATA; tx_byte is valid 3 clk after byte_evt.
REQ-021 SHALL, on byte_evt in RD_DATA, go to RD_FETCH and prefetch the next byte; received bytes are discarded in this state.
REQ-022 SHALL hold tx_byte stable except at the updates in REQ-016 and REQ-020.
REQ-023 SHALL require an sclk half-period of at least 6 clk; this is the system constraint that guarantees tx_byte is ready before the first falling edge of the next byte.
REQ-024 SHALL compute the address increment modulo 128, so 7'h7F wraps to 7'h00.
REQ-025 SHALL never assert reg_we and reg_re in the same clk.
REQ-026 SHALL NOT return to IDLE on its own: busy stays 1 until reset.
REQ-027 SHALL abort a transaction on transaction_begin mid-byte or mid-fetch with no reg_we or reg_re issued for the aborted byte, and restart in CMD.

Reset
REQ-028 SHALL, while reset=1, force the state to IDLE and drive tx_byte=TX_IDLE_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0 and busy=0.
REQ-029 SHALL give reset priority over transaction_begin and byte_evt; a reset mid-transaction discards all pending strobes.
REQ-030 SHALL, in IDLE, ignore byte_evt.

Configuration
REQ-031 SHALL, with SPI_REG_CTRL_AUTOINC_EN defined, increment reg_addr after every data byte per REQ-024.
REQ-032 SHALL, without SPI_REG_CTRL_AUTOINC_EN, hold reg_addr at the command address for the whole transaction, so repeated bytes access the same register (FIFO-style port).

Verification
REQ-033 SHALL cover: reset, then command 8'h05 followed by data 8'h3C and 8'hC3 -> reg_we pulses with (addr 5, 8'h3C), then (addr 6, 8'hC3), and reg_re is never asserted.
REQ-034 SHALL cover: command 8'h8A with reg_rdata returning 8'h10+addr -> reg_re at addr 10, tx_byte=8'h1A within 3 clk of byte_evt, then reg_re at addr 11 and tx_byte=8'h1B on the next byte.
REQ-035 SHALL cover: a write command to 8'h7F followed by 2 data bytes -> writes land at addr 127, then 0, with AUTOINC defined; both land at 127 without it.
REQ-036 SHALL cover: transaction_begin asserted in the same clk as byte_evt during WR_DATA -> no reg_we for that byte, state=CMD, and tx_byte=TX_IDLE_BYTE.
REQ-037 SHALL cover: reset asserted for 1 clk in RD_LOAD -> the next clk shows busy=0, reg_re=0 and tx_byte=TX_IDLE_BYTE, and later byte_evts are ignored.
